// File: rtl/piece_bag_gen.sv
// piece_bag_gen: turns a serial LFSR bit stream into a 7-bag sequence of
// tetromino IDs (0=I 1=O 2=T 3=S 4=Z 5=J 6=L) and holds upcoming pieces in
// a preview queue for the game-logic FSM.
// Optional feature macro: PIECE_FIRST_FILTER_EN. When it is defined, the first
// accepted piece after rst/restart can never be O, S or Z.
module piece_bag_gen #(
    parameter int QUEUE_DEPTH = 5,
    parameter int PIECE_W     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rand_bit,
    input  logic                           restart,
    input  logic                           piece_pop,
    output logic                           piece_valid,
    output logic [PIECE_W-1:0]             piece_id,
    output logic [QUEUE_DEPTH*PIECE_W-1:0] preview,
    output logic [3:0]                     preview_count,
    output logic [6:0]                     bag_mask
);

    localparam logic [3:0] DEPTH_C = 4'(QUEUE_DEPTH);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_STALL   = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cand;
    logic [1:0]         r_bit_cnt;
    logic [3:0]         r_count;
    logic               r_valid;
    logic [6:0]         r_bag_mask;
    logic [PIECE_W-1:0] r_q [QUEUE_DEPTH];

    logic               w_clear;
    logic               w_pop;
    logic               w_space;
    logic               w_sample;
    logic [2:0]         w_full;
    logic [7:0]         w_used;
    logic               w_reject;
    logic               w_push;
    logic [6:0]         w_mask_set;
    logic [6:0]         w_mask_next;
    logic [3:0]         w_wr_idx;
    logic [3:0]         w_count_next;
    logic [PIECE_W-1:0] w_shift  [QUEUE_DEPTH];
    logic [PIECE_W-1:0] w_q_next [QUEUE_DEPTH];

`ifdef PIECE_FIRST_FILTER_EN
    logic               r_first_done;
    logic               w_first_block;
`endif

    // Pop/space decision, candidate evaluation and next queue contents
    always_comb begin
        w_clear  = rst | restart;
        w_pop    = piece_pop & (r_count != 4'd0);
        w_space  = (r_count < DEPTH_C) | w_pop;
        // While stalled the queue is full, so only a pop can open space.
        w_sample = (r_state == ST_STALL) ? w_pop : w_space;

        // MSB-first candidate completed by the current bit.
        w_full   = {r_cand, rand_bit};
        // Slot 7 stands in for the invalid code 7, which is always rejected.
        w_used   = {1'b1, r_bag_mask};
        w_reject = w_used[w_full];
`ifdef PIECE_FIRST_FILTER_EN
        w_first_block = ~r_first_done &
                        ((w_full == 3'd1) | (w_full == 3'd3) | (w_full == 3'd4));
        w_reject      = w_reject | w_first_block;
`endif
        w_push = w_sample & (r_bit_cnt == 2'd2) & ~w_reject;

        // The accept that would complete the bag starts a fresh one instead.
        w_mask_set  = r_bag_mask | (7'd1 << w_full);
        w_mask_next = r_bag_mask;
        if (w_push) begin
            w_mask_next = (w_mask_set == 7'h7F) ? 7'h00 : w_mask_set;
        end

        w_count_next = r_count + {3'd0, w_push} - {3'd0, w_pop};
        w_wr_idx     = r_count - {3'd0, w_pop};

        for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
            w_shift[i] = r_q[i + 1];
        end
        w_shift[QUEUE_DEPTH - 1] = '0;

        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_q_next[i] = w_pop ? w_shift[i] : r_q[i];
            if (w_push && (4'(i) == w_wr_idx)) begin
                w_q_next[i] = w_full;
            end
        end
    end

    // Control FSM, candidate collector, bag mask and queue registers
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state    <= ST_COLLECT;
            r_cand     <= 2'd0;
            r_bit_cnt  <= 2'd0;
            r_count    <= 4'd0;
            r_valid    <= 1'b0;
            r_bag_mask <= 7'd0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            r_state <= w_space ? ST_COLLECT : ST_STALL;
            if (w_sample) begin
                r_cand    <= w_full[1:0];
                r_bit_cnt <= (r_bit_cnt == 2'd2) ? 2'd0 : r_bit_cnt + 2'd1;
            end
            r_count    <= w_count_next;
            r_valid    <= (w_count_next != 4'd0);
            r_bag_mask <= w_mask_next;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q[i] <= w_q_next[i];
            end
        end
    end

`ifdef PIECE_FIRST_FILTER_EN
    // Remembers that the opening piece of this game has been issued
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_first_done <= 1'b0;
        end else if (w_push) begin
            r_first_done <= 1'b1;
        end
    end
`endif

    // Flatten the queue onto the preview bus, head in the low bits
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            preview[i*PIECE_W +: PIECE_W] = r_q[i];
        end
    end

    assign piece_valid   = r_valid;
    assign piece_id      = r_q[0];
    assign preview_count = r_count;
    assign bag_mask      = r_bag_mask;

endmodule

// File: tb/tb_piece_bag_gen.sv
// Directed bench for piece_bag_gen: one depth-5 and one depth-8 instance
// driven by the same stimulus; each scenario checks the instance it targets.
module tb_piece_bag_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        rand_bit;
    logic        restart;
    logic        piece_pop;

    logic        valid5, valid8;
    logic [2:0]  id5, id8;
    logic [14:0] prev5;
    logic [23:0] prev8;
    logic [3:0]  cnt5, cnt8;
    logic [6:0]  mask5, mask8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piece_bag_gen #(.QUEUE_DEPTH(5), .PIECE_W(3)) u_dut5 (
        .clk(clk), .rst(rst), .rand_bit(rand_bit), .restart(restart),
        .piece_pop(piece_pop), .piece_valid(valid5), .piece_id(id5),
        .preview(prev5), .preview_count(cnt5), .bag_mask(mask5)
    );

    piece_bag_gen #(.QUEUE_DEPTH(8), .PIECE_W(3)) u_dut8 (
        .clk(clk), .rst(rst), .rand_bit(rand_bit), .restart(restart),
        .piece_pop(piece_pop), .piece_valid(valid8), .piece_id(id8),
        .preview(prev8), .preview_count(cnt8), .bag_mask(mask8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive bit (and optional pop), sample 1 ns after the edge
    task automatic step(input logic b, input logic pop = 1'b0);
        rand_bit  = b;
        piece_pop = pop;
        @(posedge clk);
        #1;
        piece_pop = 1'b0;
    endtask

    task automatic feed(input logic [2:0] id);
        step(id[2]);
        step(id[1]);
        step(id[0]);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step(1'b0);
        restart = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        rand_bit  = 1'b0;
        restart   = 1'b0;
        piece_pop = 1'b0;
        step(1'b1);
        step(1'b1);
        chk("rst_valid", 32'(valid5), 32'd0);
        chk("rst_id",    32'(id5),    32'd0);
        chk("rst_prev",  32'(prev5),  32'd0);
        chk("rst_cnt",   32'(cnt5),   32'd0);
        chk("rst_mask",  32'(mask5),  32'd0);
        rst = 1'b0;

        // First piece: T after three bits, valid in cycle 3
        step(1'b0);
        step(1'b1);
        chk("lat_not_yet", 32'(valid5), 32'd0);
        step(1'b0);
        chk("t_valid", 32'(valid5), 32'd1);
        chk("t_id",    32'(id5),    32'd2);
        chk("t_cnt",   32'(cnt5),   32'd1);
        chk("t_mask",  32'(mask5),  32'h04);

        // Code 7 rejected, then L accepted
        do_restart();
        feed(3'd7);
        chk("rej7_cnt", 32'(cnt5), 32'd0);
        feed(3'd6);
        chk("l_id",    32'(id5),   32'd6);
        chk("l_valid", 32'(valid5), 32'd1);
        chk("l_mask",  32'(mask5), 32'h40);

        // Repeat within a bag rejected
        do_restart();
        feed(3'd2);
        feed(3'd2);
        chk("rep_cnt",  32'(cnt5),  32'd1);
        chk("rep_mask", 32'(mask5), 32'h04);

        // restart wins over a simultaneous pop
        restart = 1'b1;
        step(1'b0, 1'b1);
        restart = 1'b0;
        chk("rstrt_cnt",   32'(cnt5),   32'd0);
        chk("rstrt_valid", 32'(valid5), 32'd0);
        chk("rstrt_mask",  32'(mask5),  32'd0);
        chk("rstrt_prev",  32'(prev5),  32'd0);

        // Full bag on the depth-8 instance, then a new bag, then stall
        for (int i = 0; i < 6; i++) feed(3'(i));
        chk("bag6_mask", 32'(mask8), 32'h3F);
        feed(3'd6);
        chk("bag7_mask", 32'(mask8), 32'h00);
        chk("bag7_cnt",  32'(cnt8),  32'd7);
        feed(3'd0);
        chk("bag8_cnt",  32'(cnt8),  32'd8);
        chk("bag8_id",   32'(id8),   32'd0);
        chk("bag8_mask", 32'(mask8), 32'h01);
        chk("bag8_prev", 32'(prev8), 32'(24'o06543210));
        step(1'b1);
        step(1'b1);
        chk("stall8_cnt",  32'(cnt8),  32'd8);
        chk("stall8_prev", 32'(prev8), 32'(24'o06543210));
        step(1'b0, 1'b1);
        step(1'b1);
        step(1'b0);
        chk("resume8_cnt",  32'(cnt8),  32'd8);
        chk("resume8_id",   32'(id8),   32'd1);
        chk("resume8_mask", 32'(mask8), 32'h05);
        chk("resume8_prev", 32'(prev8), 32'(24'o20654321));

        // Depth-5: push and pop in the same cycle, fill, stall, resume
        do_restart();
        for (int i = 0; i < 4; i++) feed(3'(i));
        chk("q4_cnt", 32'(cnt5), 32'd4);
        step(1'b1);
        step(1'b0);
        step(1'b1, 1'b1);
        chk("pp_cnt",  32'(cnt5),  32'd4);
        chk("pp_id",   32'(id5),   32'd1);
        chk("pp_prev", 32'(prev5), 32'(15'o05321));
        chk("pp_mask", 32'(mask5), 32'h2F);
        feed(3'd4);
        chk("full_cnt",  32'(cnt5),  32'd5);
        chk("full_prev", 32'(prev5), 32'(15'o45321));
        chk("full_mask", 32'(mask5), 32'h3F);
        step(1'b1);
        step(1'b1);
        step(1'b1, 1'b1);
        step(1'b1);
        step(1'b0);
        chk("res5_cnt",  32'(cnt5),  32'd5);
        chk("res5_id",   32'(id5),   32'd2);
        chk("res5_prev", 32'(prev5), 32'(15'o64532));
        chk("res5_mask", 32'(mask5), 32'h00);

        // Opening-piece filter (or plain acceptance when the filter is absent)
        do_restart();
        feed(3'd1);
        feed(3'd3);
`ifdef PIECE_FIRST_FILTER_EN
        chk("flt_rej_cnt", 32'(cnt5), 32'd0);
        feed(3'd2);
        chk("flt_cnt", 32'(cnt5), 32'd1);
        chk("flt_id",  32'(id5),  32'd2);
        feed(3'd1);
        chk("flt_o_cnt",  32'(cnt5),       32'd2);
        chk("flt_o_slot", 32'(prev5[5:3]), 32'd1);
`else
        chk("nf_cnt", 32'(cnt5), 32'd2);
        chk("nf_id",  32'(id5),  32'd1);
        feed(3'd2);
        feed(3'd1);
        chk("nf_rep_cnt", 32'(cnt5),  32'd3);
        chk("nf_mask",    32'(mask5), 32'h0E);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
